// File: rtl/sipo_deserializer.sv
// ============================================================================
//  Module   : sipo_deserializer
//  Brief    : Serial-in/parallel-out deserializer with a one-entry
//             valid/ready holding register and sticky overrun flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     sclr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun,
    input  logic                     clr_ovr
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;

    logic accept, last_bit, word_done, drain, load_word, drop_word;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_shift = {sh_q[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign sh_shift = {sin, sh_q[WIDTH-1:1]};
        end
    endgenerate

    assign accept    = sin_valid & ~sclr;
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign word_done = accept & last_bit;
    assign drain     = (state_q == S_FULL) & out_ready;

    // Holding-register state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (word_done) state_d = S_FULL;
            S_FULL:  if (drain && !word_done) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        load_word = 1'b0;
        drop_word = 1'b0;
        case (state_q)
            S_EMPTY: load_word = word_done;
            S_FULL: begin
                load_word = word_done & drain;
                drop_word = word_done & ~drain;
            end
            default: ;
        endcase
    end

    // Shift/count datapath; sclr outranks an incoming bit
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (sclr) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sh_d  = sh_shift;
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    // A fresh drop wins over a simultaneous clear request
    always_comb begin
        data_d = load_word ? sh_shift : data_q;
        ovr_d  = drop_word ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            ovr_q  <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == S_FULL);
    assign bit_cnt   = cnt_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// ============================================================================
//  Module   : tb_sipo_deserializer
//  Brief    : Self-checking bench; MSB-first and LSB-first instances share
//             stimulus and are compared each cycle to a bit-list model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic rstn, sin, sin_valid, sclr, out_ready, clr_ovr;

    logic [W-1:0]  od0, od1;
    logic          ov0, ov1, ovr0, ovr1;
    logic [CW-1:0] bc0, bc1;

    int n_chk  = 0;
    int n_pass = 0;
    bit en     = 1'b0;

    // Model: bits of the current partial word in arrival order
    bit         mbits [2][W];
    int         mcnt  [2];
    bit         mvalid[2];
    bit [W-1:0] mdata [2];
    bit         movr  [2];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sclr(sclr),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .bit_cnt(bc0), .overrun(ovr0), .clr_ovr(clr_ovr)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sclr(sclr),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .bit_cnt(bc1), .overrun(ovr1), .clr_ovr(clr_ovr)
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    endtask

    task automatic model_step(input int k);
        bit [W-1:0] word;
        bit done, drain;
        done = 1'b0;
        word = '0;
        if (!rstn) begin
            mcnt[k] = 0; mvalid[k] = 1'b0; mdata[k] = '0; movr[k] = 1'b0;
            return;
        end
        drain = mvalid[k] && out_ready;
        if (sclr) begin
            mcnt[k] = 0;
        end else if (sin_valid) begin
            mbits[k][mcnt[k]] = sin;
            mcnt[k]++;
            if (mcnt[k] == W) begin
                for (int i = 0; i < W; i++) begin
                    if (k == 0) word[W-1-i] = mbits[k][i];
                    else        word[i]     = mbits[k][i];
                end
                done    = 1'b1;
                mcnt[k] = 0;
            end
        end
        if (done && mvalid[k] && !drain) movr[k] = 1'b1;
        else if (clr_ovr)                movr[k] = 1'b0;
        if (done && (!mvalid[k] || drain)) begin
            mdata[k]  = word;
            mvalid[k] = 1'b1;
        end else if (drain) begin
            mvalid[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (en) begin
            check("m_valid", 0, 32'(ov0),  32'(mvalid[0]));
            check("m_data",  0, 32'(od0),  32'(mdata[0]));
            check("m_cnt",   0, 32'(bc0),  32'(mcnt[0]));
            check("m_ovr",   0, 32'(ovr0), 32'(movr[0]));
            check("m_valid", 1, 32'(ov1),  32'(mvalid[1]));
            check("m_data",  1, 32'(od1),  32'(mdata[1]));
            check("m_cnt",   1, 32'(bc1),  32'(mcnt[1]));
            check("m_ovr",   1, 32'(ovr1), 32'(movr[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b; sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        logic [W-1:0] pat;
        pat = 8'b1010_0101;
        rstn = 1'b0; sin = 1'b0; sin_valid = 1'b1; sclr = 1'b0;
        out_ready = 1'b0; clr_ovr = 1'b0;

        // Reset with live serial input
        for (int i = 0; i < 2; i++) begin
            sin = 1'($urandom);
            step();
            en = 1'b1;
        end
        check("rst_valid", 0, 32'(ov0), 0);
        check("rst_data",  0, 32'(od0), 0);
        check("rst_cnt",   0, 32'(bc0), 0);
        check("rst_ovr",   0, 32'(ovr0), 0);
        rstn = 1'b1; sin_valid = 1'b0;
        step();

        // MSB-first word 1,0,1,0,0,1,0,1 -> A5 (also A5 on the LSB instance)
        out_ready = 1'b1;
        for (int i = W - 1; i >= 0; i--) send_bit(pat[i]);
        check("msb_valid", 0, 32'(ov0), 1);
        check("msb_data",  0, 32'(od0), 32'hA5);
        check("lsb_data",  1, 32'(od1), 32'hA5);
        step();
        check("msb_onecyc", 0, 32'(ov0), 0);

        // LSB-first with idle gaps; bit_cnt must hold during gaps
        for (int i = 0; i < W; i++) begin
            send_bit(pat[W-1-i]);
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                if (i < W - 1) check("gap_cnt", 1, 32'(bc1), 32'(i + 1));
                step();
            end
        end
        check("gap_data", 1, 32'(od1), 32'hA5);
        repeat (2) step();

        // Back-pressure: second word dropped, overrun set
        out_ready = 1'b0;
        send_word(8'h3C);
        send_word(8'hFF);
        check("bp_data",  0, 32'(od0),  32'h3C);
        check("bp_ovr",   0, 32'(ovr0), 1);
        check("bp_valid", 0, 32'(ov0),  1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("bp_drain", 0, 32'(ov0), 0);
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        check("bp_clr", 0, 32'(ovr0), 0);

        // Drain coincides with completion of the next word
        send_word(8'h12);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0) out_ready = 1'b1;
            send_bit(8'h34 >> i);
        end
        out_ready = 1'b0;
        check("sim_data",  0, 32'(od0),  32'h34);
        check("sim_valid", 0, 32'(ov0),  1);
        check("sim_ovr",   0, 32'(ovr0), 0);
        out_ready = 1'b1; step();

        // Abort by sclr
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        sclr = 1'b1; sin_valid = 1'b1; sin = 1'b1; step();
        sclr = 1'b0; sin_valid = 1'b0;
        check("sclr_cnt", 0, 32'(bc0), 0);
        send_word(8'h81);
        check("sclr_data", 0, 32'(od0), 32'h81);
        step();

        // Abort by reset
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        rstn = 1'b0; step();
        check("rstw_valid", 0, 32'(ov0), 0);
        check("rstw_cnt",   0, 32'(bc0), 0);
        rstn = 1'b1;
        send_word(8'h81);
        check("rstw_data", 0, 32'(od0), 32'h81);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sin       = 1'($urandom);
            sin_valid = ($urandom_range(99, 0) < 75);
            sclr      = ($urandom_range(99, 0) < 3);
            out_ready = ($urandom_range(99, 0) < 20);
            clr_ovr   = ($urandom_range(99, 0) < 5);
            rstn      = ($urandom_range(999, 0) >= 5);
            step();
        end
        rstn = 1'b1; sin_valid = 1'b0; sclr = 1'b0; clr_ovr = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
